mdr_mem_unit: RTL and testbench

- Memory Data Register plus memory-handshake sequencer; sits directly beside the datapath bus.
- Consumes the bus output (bus_in) and drives the MDR source into the bus multiplexer (mdr_out).
- Loads MDR from the bus or from memory, writes MDR to memory, and sequences a req/ack handshake with a bounded wait.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/mem_wait_timer.sv | 34 +++
 rtl/mdr_mem_unit.sv | 129 ++++++++++++
 tb/tb_mdr_mem_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default bus/address widths, memory wait bound,
// and the MDR sequencer state encoding.
package cpu_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 9;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mdr_state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Bounded-wait counter for the memory handshake. The whole module exists only
// when MDR_MEM_TIMEOUT_EN is defined; without it the sequencer waits forever.
// The count restarts on start, advances on enable, saturates at TIMEOUT and
// flags expired once TIMEOUT-1 wait cycles have been seen.
`ifdef MDR_MEM_TIMEOUT_EN
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic clear,
  input  logic start,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] waitCnt;

  // Restart on reset or a new access; otherwise count wait cycles, never wrapping.
  always_ff @(posedge clock) begin
    if (clear || start) begin
      waitCnt <= '0;
    end else if (enable && (waitCnt != CNT_MAX)) begin
      waitCnt <= waitCnt + CNT_W'(1);
    end
  end

  assign expired = (waitCnt == CNT_LAST);

endmodule
`endif

// File: rtl/mdr_mem_unit.sv
// Memory Data Register with req/ack memory sequencer. MDR loads from the bus
// in IDLE, or from memory on a read; a write drives MDR out as mem_wdata.
// Optional bounded wait: define MDR_MEM_TIMEOUT_EN to abort an access after
// TIMEOUT cycles without mem_ack and raise the sticky err flag.
module mdr_mem_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mdr_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              rd_start,
  input  logic              wr_start,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mdr_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  if (TIMEOUT < 1) begin : gBadTimeout
    $error("mdr_mem_unit: TIMEOUT must be at least 1");
  end

  mdr_state_t        state;
  logic [DATA_W-1:0] mdr;
  logic              startHit;
  logic              timeoutHit;

  assign startHit = (state == IDLE) && (rd_start || wr_start);

`ifdef MDR_MEM_TIMEOUT_EN
  logic timerExpired;
  logic errFlag;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) uWaitTimer (
    .clock   (clock),
    .clear   (clear),
    .start   (startHit),
    .enable  ((state == ACCESS) && !mem_ack),
    .expired (timerExpired)
  );

  assign timeoutHit = (state == ACCESS) && timerExpired && !mem_ack;

  // Sticky timeout flag: cleared by reset or by the next accepted start.
  always_ff @(posedge clock) begin
    if (clear) begin
      errFlag <= 1'b0;
    end else if (startHit) begin
      errFlag <= 1'b0;
    end else if (timeoutHit) begin
      errFlag <= 1'b1;
    end
  end

  assign err = errFlag;
`else
  assign timeoutHit = 1'b0;
  assign err        = 1'b0;
`endif

  // Sequencer FSM with registered handshake outputs; MDR and address updates live here too.
  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= IDLE;
      mdr      <= '0;
      mem_addr <= '0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_start || rd_start) begin
            state    <= ACCESS;
            mem_we   <= wr_start;
            mem_addr <= addr_in;
            mem_req  <= 1'b1;
            busy     <= 1'b1;
          end else if (mdr_in) begin
            mdr <= bus_in;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            state   <= DONE;
            mem_req <= 1'b0;
            done    <= 1'b1;
            if (!mem_we) begin
              mdr <= mem_rdata;
            end
          end else if (timeoutHit) begin
            state   <= DONE;
            mem_req <= 1'b0;
            done    <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign mdr_out   = mdr;
  assign mem_wdata = mdr;

endmodule

// File: tb/tb_mdr_mem_unit.sv
// Scoreboard bench for mdr_mem_unit: expected MDR/err results are queued when
// an operation is launched and compared when the unit completes it.
module tb_mdr_mem_unit;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  localparam int TO     = 15;

  typedef struct {
    logic [DATA_W-1:0] mdr;
    logic              err;
  } expEntry_t;

  logic              clock = 1'b0;
  logic              clear;
  logic [DATA_W-1:0] bus_in;
  logic              mdr_in;
  logic [ADDR_W-1:0] addr_in;
  logic              rd_start;
  logic              wr_start;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mdr_out;
  logic              busy;
  logic              done;
  logic              err;

  expEntry_t sbQ[$];
  int nChecks = 0;
  int nPass   = 0;
  int reqCycles;
  bit sawDone;

  mdr_mem_unit #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TO)
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .bus_in    (bus_in),
    .mdr_in    (mdr_in),
    .addr_in   (addr_in),
    .rd_start  (rd_start),
    .wr_start  (wr_start),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mdr_out   (mdr_out),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) begin
      nPass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Wait (bounded) for the done pulse, counting request cycles on the way,
  // then compare MDR and err against the oldest queued expectation.
  task automatic finishAccess(input string tag, input int maxCyc);
    expEntry_t e;
    int n;
    n = 0;
    reqCycles = 0;
    while (!done && n < maxCyc) begin
      if (mem_req) reqCycles++;
      tick();
      n++;
    end
    checkVal({tag, "_done"}, done, 1);
    checkVal({tag, "_reqlow"}, mem_req, 0);
    if (sbQ.size() == 0) begin
      checkVal({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sbQ.pop_front();
      checkVal({tag, "_mdr"}, mdr_out, e.mdr);
      checkVal({tag, "_err"}, err, e.err);
    end
  endtask

  task automatic busLoad(input logic [DATA_W-1:0] val);
    expEntry_t e;
    mdr_in = 1'b1;
    bus_in = val;
    e.mdr = val;
    e.err = 1'b0;
    sbQ.push_back(e);
    tick();
    mdr_in = 1'b0;
    e = sbQ.pop_front();
    checkVal("busload_mdr", mdr_out, e.mdr);
    checkVal("busload_req", mem_req, 0);
  endtask

  initial begin
    expEntry_t e;

    clear = 1'b1; mdr_in = 1'b1; bus_in = 32'hFFFF_FFFF;
    addr_in = '0; rd_start = 1'b0; wr_start = 1'b0;
    mem_rdata = '0; mem_ack = 1'b0;

    // Reset held two cycles while mdr_in is asserted.
    tick();
    tick();
    checkVal("rst_mdr", mdr_out, 0);
    checkVal("rst_req", mem_req, 0);
    checkVal("rst_done", done, 0);
    checkVal("rst_err", err, 0);
    checkVal("rst_busy", busy, 0);
    clear = 1'b0; mdr_in = 1'b0;

    // Bus load.
    busLoad(32'h1234_5678);

    // Read with ack after three wait cycles.
    addr_in = 9'h05A; rd_start = 1'b1;
    e.mdr = 32'hDEAD_BEEF; e.err = 1'b0; sbQ.push_back(e);
    tick();
    rd_start = 1'b0; addr_in = 9'h000;
    for (int i = 0; i < 3; i++) begin
      checkVal("rd_req", mem_req, 1);
      checkVal("rd_we", mem_we, 0);
      checkVal("rd_addr", mem_addr, 9'h05A);
      checkVal("rd_busy", busy, 1);
      checkVal("rd_mdr_hold", mdr_out, 32'h1234_5678);
      tick();
    end
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    finishAccess("rd", 5);
    tick();
    checkVal("rd_done_1cyc", done, 0);
    checkVal("rd_busy_end", busy, 0);

    // Write with both starts high; rd_start during busy must be ignored.
    busLoad(32'h0000_00A5);
    addr_in = 9'h1A3; rd_start = 1'b1; wr_start = 1'b1;
    e.mdr = 32'h0000_00A5; e.err = 1'b0; sbQ.push_back(e);
    tick();
    wr_start = 1'b0;
    checkVal("wr_we", mem_we, 1);
    checkVal("wr_wdata", mem_wdata, 32'h0000_00A5);
    checkVal("wr_addr", mem_addr, 9'h1A3);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    checkVal("wr_req", mem_req, 1);
    tick();
    mem_ack = 1'b0; rd_start = 1'b0;
    finishAccess("wr", 5);
    tick();
    checkVal("wr_no_queue_req", mem_req, 0);
    checkVal("wr_no_queue_busy", busy, 0);
    tick();
    checkVal("wr_no_queue_req2", mem_req, 0);

`ifdef MDR_MEM_TIMEOUT_EN
    // Timeout: no ack ever arrives.
    rd_start = 1'b1;
    e.mdr = 32'h0000_00A5; e.err = 1'b1; sbQ.push_back(e);
    tick();
    rd_start = 1'b0;
    finishAccess("to", 40);
    checkVal("to_req_cycles", reqCycles, TO);
    tick();
    checkVal("to_err_sticky", err, 1);
    rd_start = 1'b1;
    e.mdr = 32'h7777_0077; e.err = 1'b0; sbQ.push_back(e);
    tick();
    rd_start = 1'b0;
    checkVal("to_err_cleared", err, 0);
    mem_ack = 1'b1; mem_rdata = 32'h7777_0077;
    tick();
    mem_ack = 1'b0;
    finishAccess("to_rd", 5);
    tick();
`else
    // Without the bounded wait the access stays pending until ack.
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    reqCycles = 0; sawDone = 1'b0;
    for (int i = 0; i < TO + 5; i++) begin
      if (mem_req) reqCycles++;
      if (done) sawDone = 1'b1;
      tick();
    end
    checkVal("nto_req_cycles", reqCycles, TO + 5);
    checkVal("nto_no_done", sawDone, 0);
    checkVal("nto_err", err, 0);
    e.mdr = 32'h7777_0077; e.err = 1'b0; sbQ.push_back(e);
    mem_ack = 1'b1; mem_rdata = 32'h7777_0077;
    tick();
    mem_ack = 1'b0;
    finishAccess("nto_rd", 5);
    tick();
`endif

    // Reset in the second ACCESS cycle; a late ack must not revive anything.
    addr_in = 9'h0FF; rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkVal("mid_rst_req", mem_req, 0);
    checkVal("mid_rst_mdr", mdr_out, 0);
    checkVal("mid_rst_done", done, 0);
    checkVal("mid_rst_busy", busy, 0);
    checkVal("mid_rst_addr", mem_addr, 0);
    mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
    tick();
    mem_ack = 1'b0;
    checkVal("late_ack_mdr", mdr_out, 0);
    checkVal("late_ack_done", done, 0);
    tick();
    checkVal("late_ack_done2", done, 0);
    checkVal("late_ack_req", mem_req, 0);
    checkVal("sb_drained", sbQ.size(), 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
